// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 fetch stage with a req/ack instruction-memory port and a two-entry
// instruction buffer (output slot plus one prefetch slot) with taken-branch redirect.
module fetch_unit #(
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset_L,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] Instr,
    output logic [63:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        BranchTaken,
    input  logic        BranchReg,
    input  logic [63:0] BusImm,
    input  logic [63:0] RegTarget
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT_SLOT, DRAIN} state_t;
    state_t      state, state_n;
    logic [63:0] fa, fa_n, drain_addr, out_pc_n, pf_pc, pf_pc_n, target;
    logic [31:0] instr_n, pf_instr, pf_instr_n;
    logic        out_valid_n, pf_valid, pf_valid_n, consume, redirect, ack;

    assign consume   = InstrValid && InstrReady;
    assign redirect  = consume && BranchTaken;
    assign ack       = imem_ack && state == FETCH;
    assign target    = BranchReg ? RegTarget : InstrPC + (BusImm << 2);
    assign imem_req  = state == FETCH || state == DRAIN;
    assign imem_addr = state == DRAIN ? drain_addr : fa;

    // Consume shifts the prefetch slot forward first; ack data then fills the first free slot.
    always_comb begin
        fa_n        = ack ? fa + 64'd4 : fa;
        out_valid_n = consume ? pf_valid : InstrValid;
        instr_n     = consume ? pf_instr : Instr;
        out_pc_n    = consume ? pf_pc : InstrPC;
        pf_valid_n  = pf_valid && !consume;
        pf_instr_n  = pf_instr;
        pf_pc_n     = pf_pc;
        if (ack && !out_valid_n) begin
            out_valid_n = 1'b1;
            instr_n     = imem_data;
            out_pc_n    = fa;
        end else if (ack) begin
            pf_valid_n = 1'b1;
            pf_instr_n = imem_data;
            pf_pc_n    = fa;
        end
        if (redirect) begin
            out_valid_n = 1'b0;
            pf_valid_n  = 1'b0;
            fa_n        = target;
        end
        state_n = redirect ? (state == FETCH && !imem_ack ? DRAIN : FETCH)
                : state == IDLE ? FETCH
                : state == FETCH ? (out_valid_n && pf_valid_n ? WAIT_SLOT : FETCH)
                : state == WAIT_SLOT ? (consume ? FETCH : WAIT_SLOT)
                : (imem_ack ? FETCH : DRAIN);
    end

    // drain_addr tracks FA until DRAIN, then freezes on the abandoned in-flight address.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state      <= IDLE;
            fa         <= PC_RESET;
            drain_addr <= '0;
            InstrValid <= 1'b0;
            Instr      <= '0;
            InstrPC    <= '0;
            pf_valid   <= 1'b0;
            pf_instr   <= '0;
            pf_pc      <= '0;
        end else begin
            state      <= state_n;
            fa         <= fa_n;
            drain_addr <= state == DRAIN ? drain_addr : fa;
            InstrValid <= out_valid_n;
            Instr      <= instr_n;
            InstrPC    <= out_pc_n;
            pf_valid   <= pf_valid_n;
            pf_instr   <= pf_instr_n;
            pf_pc      <= pf_pc_n;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a program-order model
// (expected next PC, memory contents as a function of address, hold/flush/stability rules).
module tb_fetch_unit;
    localparam logic [63:0] PC_RST = 64'h0;

    logic        CLK, Reset_L, imem_req, imem_ack, InstrValid, InstrReady, BranchTaken, BranchReg;
    logic [63:0] imem_addr, InstrPC, BusImm, RegTarget;
    logic [31:0] imem_data, Instr;

    int          n_checks, n_fail, n_cons, cons0, lat, cnt, stall, off;
    logic        hold, flush_next, pend, found, seen;
    logic [63:0] exp_pc, hold_pc, pend_addr;
    logic [31:0] hold_instr;

    fetch_unit #(.PC_RESET(PC_RST)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .Instr(Instr), .InstrPC(InstrPC),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .BranchTaken(BranchTaken),
        .BranchReg(BranchReg), .BusImm(BusImm), .RegTarget(RegTarget)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        hold = 1'b0;
        flush_next = 1'b0;
        pend = 1'b0;
        cnt = 0;
        stall = 0;
        exp_pc = PC_RST;
    endtask

    // Observe outputs at the falling edge, then act as the instruction memory.
    task automatic sample();
        @(negedge CLK);
        stall = InstrValid ? 0 : stall + 1;
        chk("stall", 64'(stall <= 30), 64'(1));
        if (flush_next) chk("flush", 64'(InstrValid), 64'(0));
        if (hold) begin
            chk("hold_valid", 64'(InstrValid), 64'(1));
            chk("hold_pc", InstrPC, hold_pc);
            chk("hold_instr", 64'(Instr), 64'(hold_instr));
        end
        if (InstrValid) begin
            chk("pc", InstrPC, exp_pc);
            chk("instr", 64'(Instr), 64'(word(InstrPC)));
        end
        if (pend) begin
            chk("req_held", 64'(imem_req), 64'(1));
            chk("addr_stable", imem_addr, pend_addr);
        end
        if (imem_req && cnt + 1 >= lat) begin
            imem_ack = 1'b1;
            imem_data = word(imem_addr);
            cnt = 0;
        end else begin
            imem_ack = 1'b0;
            imem_data = 32'h0;
            cnt = imem_req ? cnt + 1 : 0;
        end
        pend = imem_req && !imem_ack;
        pend_addr = imem_addr;
    endtask

    // Act as the consumer and advance the program-order model on a consume.
    task automatic drive(input logic rdy, input logic bt, input logic br,
                         input logic [63:0] imm, input logic [63:0] rt);
        InstrReady = rdy;
        BranchTaken = bt;
        BranchReg = br;
        BusImm = imm;
        RegTarget = rt;
        hold = InstrValid && !rdy;
        hold_pc = InstrPC;
        hold_instr = Instr;
        flush_next = InstrValid && rdy && bt;
        if (InstrValid && rdy) begin
            n_cons++;
            exp_pc = !bt ? exp_pc + 64'd4 : br ? rt : exp_pc + (imm << 2);
        end
    endtask

    task automatic release_rst(input logic stray);
        Reset_L = 1'b1;
        imem_ack = stray;
        imem_data = 32'hBAD0_BAD0;
        clear_model();
    endtask

    task automatic reset_pulse(input logic stray);
        Reset_L = 1'b0;
        clear_model();
        #1;
        chk("arst_valid", 64'(InstrValid), 64'(0));
        chk("arst_req", 64'(imem_req), 64'(0));
        chk("arst_instr", 64'(Instr), 64'(0));
        chk("arst_pc", InstrPC, 64'(0));
        repeat (2) begin
            sample();
            drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        end
        release_rst(stray);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        n_cons = 0;
        lat = 1;
        Reset_L = 1'b0;
        imem_ack = 1'b0;
        imem_data = 32'h0;
        InstrReady = 1'b0;
        BranchTaken = 1'b0;
        BranchReg = 1'b0;
        BusImm = 64'h0;
        RegTarget = 64'h0;
        clear_model();

        sample();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        sample();
        chk("rst_valid", 64'(InstrValid), 64'(0));
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_instr", 64'(Instr), 64'(0));
        chk("rst_pc", InstrPC, 64'(0));
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        release_rst(1'b0);

        for (int k = 0; k < 12; k++) begin
            sample();
            chk("seq_addr", imem_addr, 64'(k * 4));
            chk("seq_req", 64'(imem_req), 64'(1));
            if (k > 0) chk("no_bubble", 64'(InstrValid), 64'(1));
            drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        end

        reset_pulse(1'b0);
        for (int k = 0; k < 6; k++) begin
            sample();
            drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        end
        chk("full_req", 64'(imem_req), 64'(0));
        sample();
        drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        sample();
        chk("refill_req", 64'(imem_req), 64'(1));
        chk("refill_addr", imem_addr, 64'h8);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        sample();
        chk("refull_req", 64'(imem_req), 64'(0));
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            sample();
            if (InstrValid && InstrPC == 64'h10) begin
                drive(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
                found = 1'b1;
            end else drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        end
        chk("back_branch_seen", 64'(found), 64'(1));
        lat = 3;
        sample();
        chk("back_addr", imem_addr, 64'hC);
        chk("back_req", 64'(imem_req), 64'(1));
        drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);

        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            sample();
            if (InstrValid && InstrPC == 64'h14 && imem_req && imem_addr == 64'h18 && !imem_ack) begin
                drive(1'b1, 1'b1, 1'b1, 64'h0, 64'h100);
                found = 1'b1;
            end else drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        end
        chk("drain_branch_seen", 64'(found), 64'(1));
        sample();
        chk("drain_req", 64'(imem_req), 64'(1));
        chk("drain_addr", imem_addr, 64'h18);
        drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            sample();
            found = imem_req && imem_addr == 64'h100;
            drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        end
        chk("redirect_addr", 64'(found), 64'(1));

        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            sample();
            found = InstrValid;
            drive(1'b1, InstrValid, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        end
        found = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            sample();
            if (InstrValid && InstrPC == 64'h0 && seen) found = 1'b1;
            if (InstrValid && InstrPC == 64'hFFFF_FFFF_FFFF_FFFC) seen = 1'b1;
            drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        end
        chk("wrap_seen", 64'(found), 64'(1));

        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            sample();
            found = imem_req && !imem_ack;
            drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        end
        chk("midreq_seen", 64'(found), 64'(1));
        reset_pulse(1'b1);
        lat = 2;
        sample();
        chk("restart_req", 64'(imem_req), 64'(1));
        chk("restart_addr", imem_addr, PC_RST);
        drive(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);

        cons0 = n_cons;
        for (int k = 0; k < 1500; k++) begin
            sample();
            if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(1, 4));
            off = int'($urandom_range(0, 32)) - 16;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                  64'(off), 64'($urandom_range(0, 1023)) << 2);
        end
        chk("progress", 64'(n_cons - cons0 >= 150), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
